cpu_mem_bridge: RTL
===================

# cpu_mem_bridge

Request bridge between the 6502 core's memory port and `memc`. It accepts one CPU read or write at a time over a valid/ready handshake and converts it into a single-cycle `memc_read_enable` or `memc_write_enable` pulse. Read data is returned on a one-cycle response strobe. CPU requests are held off while `memc` reports busy, which covers its post-reset BIST. A bounded wait on that BIST is flagged as an init failure.

## Interface
- `DATA_WIDTH`, 8, data bus width
- `ADDR_WIDTH`, 16, address bus width
- `READ_LATENCY`, 2, cycles from the `memc_read_enable` cycle to the cycle `memc_read_data` is valid; legal range 1–7
- `INIT_TIMEOUT`, 400000, maximum cycles to wait for `memc_busy` low after reset
- `CNT_WIDTH`, 20, init counter width; must satisfy 2^CNT_WIDTH > INIT_TIMEOUT
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-low
- `cpu_req_valid` in 1: request present
- `cpu_req_ready` out 1: request accepted when high together with `cpu_req_valid`
- `cpu_req_we` in 1: 1 = write, 0 = read
- `cpu_req_addr` in ADDR_WIDTH: request address
- `cpu_req_wdata` in DATA_WIDTH: write data
- `cpu_rsp_valid` out 1: one-cycle read-data strobe; no flow control; writes produce no response
- `cpu_rsp_rdata` out DATA_WIDTH: read data
- `cpu_rsp_err` out 1: qualifies `cpu_rsp_valid`; memc went busy during the read
- `init_done` out 1: memc left busy after reset; sticky until reset
- `init_error` out 1: init timeout expired; sticky until reset
- `memc_read_enable` out 1: read command pulse
- `memc_write_enable` out 1: write command pulse
- `memc_addr` out ADDR_WIDTH: command address
- `memc_write_data` out DATA_WIDTH: command write data
- `memc_read_data` in DATA_WIDTH: memc read data
- `memc_busy` in 1: memc not accepting commands

## Operation
- States: INIT, IDLE, ISSUE, RD_WAIT, GAP, ERROR. One-hot encoding.
- Reset (`reset`=0 at a clk edge): state INIT, init counter 0, all outputs 0, `cpu_rsp_rdata` 0. Any in-flight transaction is dropped with no response.
- INIT:
  - `memc_busy`=0 → IDLE and set `init_done`.
  - Otherwise, when the counter reaches INIT_TIMEOUT-1 → ERROR.
  - Otherwise the counter increments.
  - If `memc_busy`=0 and the counter reaches terminal count in the same cycle, IDLE wins.
- IDLE: `cpu_req_ready` = !`memc_busy`, the only combinational output. On accept, register addr, wdata and we, then go to ISSUE.
- ISSUE: for exactly one cycle, drive the registered addr and wdata to memc and raise the matching enable.
  - Read → RD_WAIT.
  - Write → GAP.
- RD_WAIT: count READ_LATENCY cycles, capture `memc_read_data` in the last one, then go to IDLE. `cpu_rsp_valid` is high in the following cycle.
- GAP: one recovery cycle so memc can return to its own idle state, then go to IDLE.
- Error tracking: if `memc_busy` is sampled high in ISSUE or RD_WAIT, `cpu_rsp_err`=1 with that read's response. The transaction still completes.
- ERROR: terminal. `init_error`=1, `cpu_req_ready`=0. Only reset exits.
- Enables are never asserted outside ISSUE. Both enables are never high together.

## Timing
- Request accepted in cycle A:
  - Enable high in A+1.
  - Read data sampled in A+1+READ_LATENCY.
  - `cpu_rsp_valid` high in A+2+READ_LATENCY. With the default latency this is A+4.
- Read turnaround: the state is IDLE in the `cpu_rsp_valid` cycle, so the next accept can occur in A+2+READ_LATENCY.
- Write turnaround: ISSUE A+1, GAP A+2, IDLE A+3. Fastest write-to-write accept spacing is 3 cycles.
- `cpu_req_ready` is low in every state except IDLE. A request held with valid=1 through busy is accepted in the first IDLE cycle with `memc_busy`=0.
- `cpu_rsp_rdata` holds its value until the next read capture.

## Structure
- Package `mem_bridge_pkg`: state index constants, default READ_LATENCY and INIT_TIMEOUT, and the shared BIST patterns 8'h55 and 8'hAA.
- No sub-module; the FSM, init counter and latency counter live in one module.

## Test plan
- Reset release with `memc_busy` high for 10 cycles, then low:
  - `init_done` rises in the cycle after busy falls.
  - `cpu_req_ready` is low throughout the busy period.
- INIT_TIMEOUT=16 and busy stuck high: `init_error`=1 after 16 cycles; valid requests are never accepted.
- Write 0x3C to 0x0200 then read 0x0200, memc model latency 2:
  - One-cycle write enable with addr 0x0200 and data 0x3C.
  - `cpu_rsp_valid` with 0x3C and err=0, 4 cycles after the read accept.
- Back-to-back reads of 0x0000 and 0xFFFF with valid held high: accepts 4 cycles apart, two responses in order.
- `memc_busy` pulsed high during RD_WAIT: the response arrives on schedule with `cpu_rsp_err`=1.
- Reset asserted in RD_WAIT: no `cpu_rsp_valid`, all outputs 0 next cycle, state INIT.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared constants for the CPU-to-memc request bridge: FSM state encoding,
// default timing parameters and the memc BIST data patterns.
package mem_bridge_pkg;

  localparam int unsigned NUM_STATES = 6;

  localparam int unsigned IDX_INIT    = 0;
  localparam int unsigned IDX_IDLE    = 1;
  localparam int unsigned IDX_ISSUE   = 2;
  localparam int unsigned IDX_RD_WAIT = 3;
  localparam int unsigned IDX_GAP     = 4;
  localparam int unsigned IDX_ERROR   = 5;

  localparam int unsigned DEF_READ_LATENCY = 2;
  localparam int unsigned DEF_INIT_TIMEOUT = 400000;
  localparam int unsigned LAT_WIDTH        = 3;

  localparam logic [7:0] BIST_PAT_A = 8'h55;
  localparam logic [7:0] BIST_PAT_B = 8'hAA;

  typedef enum logic [NUM_STATES-1:0] {
    ST_INIT    = NUM_STATES'(1) << IDX_INIT,
    ST_IDLE    = NUM_STATES'(1) << IDX_IDLE,
    ST_ISSUE   = NUM_STATES'(1) << IDX_ISSUE,
    ST_RD_WAIT = NUM_STATES'(1) << IDX_RD_WAIT,
    ST_GAP     = NUM_STATES'(1) << IDX_GAP,
    ST_ERROR   = NUM_STATES'(1) << IDX_ERROR
  } state_e;

endpackage

// File: rtl/cpu_mem_bridge.sv
// Single-outstanding request bridge from the 6502 memory port to memc, with
// a bounded wait on memc's post-reset BIST.
module cpu_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned INIT_TIMEOUT = DEF_INIT_TIMEOUT,
  parameter int unsigned CNT_WIDTH    = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_rsp_valid,
  output logic [DATA_WIDTH-1:0] cpu_rsp_rdata,
  output logic                  cpu_rsp_err,
  output logic                  init_done,
  output logic                  init_error,
  output logic                  memc_read_enable,
  output logic                  memc_write_enable,
  output logic [ADDR_WIDTH-1:0] memc_addr,
  output logic [DATA_WIDTH-1:0] memc_write_data,
  input  logic [DATA_WIDTH-1:0] memc_read_data,
  input  logic                  memc_busy
);

  state_e                 state, state_next;
  logic [CNT_WIDTH-1:0]   init_cnt, init_cnt_next;
  logic [LAT_WIDTH-1:0]   lat_cnt, lat_cnt_next;
  logic                   we_q, we_next;
  logic                   err_q, err_next;
  logic                   accept;
  logic                   rsp_valid_next, rsp_err_next;
  logic [DATA_WIDTH-1:0]  rdata_next, wdata_next;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic                   init_done_next, init_error_next;
  logic                   rd_en_next, wr_en_next;

  assign cpu_req_ready = (state == ST_IDLE) && !memc_busy;
  assign accept        = cpu_req_ready && cpu_req_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_next;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_next     = state;
    init_cnt_next  = init_cnt;
    lat_cnt_next   = lat_cnt;
    we_next        = we_q;
    err_next       = err_q;
    addr_next      = memc_addr;
    wdata_next     = memc_write_data;
    rdata_next     = cpu_rsp_rdata;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    init_done_next = init_done;

    unique case (state)
      ST_INIT: begin
        // Busy dropping wins over a simultaneous terminal count.
        if (!memc_busy) begin
          state_next     = ST_IDLE;
          init_done_next = 1'b1;
        end else if (init_cnt == CNT_WIDTH'(INIT_TIMEOUT - 1)) begin
          state_next = ST_ERROR;
        end else begin
          init_cnt_next = init_cnt + CNT_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          addr_next  = cpu_req_addr;
          wdata_next = cpu_req_wdata;
          we_next    = cpu_req_we;
          err_next   = 1'b0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        err_next     = err_q | memc_busy;
        lat_cnt_next = '0;
        state_next   = we_q ? ST_GAP : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_cnt == LAT_WIDTH'(READ_LATENCY - 1)) begin
          rdata_next     = memc_read_data;
          rsp_valid_next = 1'b1;
          rsp_err_next   = err_q | memc_busy;
          state_next     = ST_IDLE;
        end else begin
          lat_cnt_next = lat_cnt + LAT_WIDTH'(1);
          err_next     = err_q | memc_busy;
        end
      end
      ST_GAP:   state_next = ST_IDLE;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_INIT;
    endcase

    // Enables are registered from the next state so they coincide with ISSUE.
    rd_en_next      = (state_next == ST_ISSUE) && !we_next;
    wr_en_next      = (state_next == ST_ISSUE) && we_next;
    init_error_next = (state_next == ST_ERROR);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      init_cnt          <= '0;
      lat_cnt           <= '0;
      we_q              <= 1'b0;
      err_q             <= 1'b0;
      cpu_rsp_valid     <= 1'b0;
      cpu_rsp_rdata     <= '0;
      cpu_rsp_err       <= 1'b0;
      init_done         <= 1'b0;
      init_error        <= 1'b0;
      memc_read_enable  <= 1'b0;
      memc_write_enable <= 1'b0;
      memc_addr         <= '0;
      memc_write_data   <= '0;
    end else begin
      init_cnt          <= init_cnt_next;
      lat_cnt           <= lat_cnt_next;
      we_q              <= we_next;
      err_q             <= err_next;
      cpu_rsp_valid     <= rsp_valid_next;
      cpu_rsp_rdata     <= rdata_next;
      cpu_rsp_err       <= rsp_err_next;
      init_done         <= init_done_next;
      init_error        <= init_error_next;
      memc_read_enable  <= rd_en_next;
      memc_write_enable <= wr_en_next;
      memc_addr         <= addr_next;
      memc_write_data   <= wdata_next;
    end
  end

endmodule
